// File: rtl/encode.sv
// encode: Kyber ByteEncode_l packer.
// Packs 256 coefficients of l bits each into a little-endian bit stream
// and presents that stream as 64-bit words. Byte 0 of a word is carried in
// o_bytes[63:56]. The coefficient width l is latched when a polynomial starts.
module encode #(
    parameter int unsigned N_COEFFS = 256
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [3:0]  i_l,
    input  logic [11:0] i_coeffs,
    input  logic        i_coeffs_valid,
    output logic        o_coeffs_ready,
    output logic [63:0] o_bytes,
    output logic        o_bytes_valid,
    input  logic        i_bytes_ready,
    output logic        o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PACK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned ACC_W    = 76;
    localparam logic [8:0]  CNT_MAX  = 9'(N_COEFFS);
    localparam logic [6:0]  WORD_BITS = 7'd64;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [6:0]       fill_q,  fill_d;
    logic [8:0]       cnt_q,   cnt_d;
    logic [3:0]       l_q,     l_d;

    logic             accept;
    logic             emit;
    logic [11:0]      coeff_masked;

    // Only the widths used by Kyber are accepted; anything else leaves the block idle.
    function automatic logic legal_l(input logic [3:0] l);
        return (l == 4'd1) || (l == 4'd4) || (l == 4'd5) ||
               (l == 4'd10) || (l == 4'd11) || (l == 4'd12);
    endfunction

    // Low-l-bits mask for the incoming coefficient.
    function automatic logic [11:0] coeff_mask(input logic [3:0] l);
        logic [11:0] m;
        m = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (i < 32'(l)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Handshake qualifiers and output views of the registered state.
    always_comb begin
        o_coeffs_ready = (state_q == S_PACK) && (fill_q < WORD_BITS) && (cnt_q < CNT_MAX);
        o_bytes_valid  = (state_q == S_PACK) && (fill_q >= WORD_BITS);
        o_done         = (state_q == S_DONE);
        accept         = o_coeffs_ready && i_coeffs_valid;
        emit           = o_bytes_valid && i_bytes_ready;
        coeff_masked   = i_coeffs & coeff_mask(l_q);
    end

    // Byte swap: oldest stream byte (acc[7:0]) goes to the top of the word.
    always_comb begin
        o_bytes = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            o_bytes[8*(7-b) +: 8] = acc_q[8*b +: 8];
        end
    end

    // Next-state logic: start latching, coefficient accumulation, word emission.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && legal_l(i_l)) begin
                    l_d     = i_l;
                    acc_d   = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    state_d = S_PACK;
                end
            end
            S_PACK: begin
                // accept needs fill < 64 and emit needs fill >= 64, so at most one fires.
                if (accept) begin
                    acc_d  = acc_q | ({64'd0, coeff_masked} << fill_q);
                    fill_d = fill_q + {3'd0, l_q};
                    cnt_d  = cnt_q + 9'd1;
                end else if (emit) begin
                    acc_d  = acc_q >> 64;
                    fill_d = fill_q - WORD_BITS;
                    // 256*l is a multiple of 64, so the final word leaves the accumulator empty.
                    if ((cnt_q == CNT_MAX) && (fill_q == WORD_BITS)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
        end
    end

endmodule

// File: tb/tb_encode.sv
// tb_encode: directed table-driven bench for encode against a bit-level
// ByteEncode model (stream bit i*l+j = bit j of coefficient i).
module tb_encode;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start;
    logic [3:0]  i_l;
    logic [11:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_coeffs_ready;
    logic [63:0] o_bytes;
    logic        o_bytes_valid;
    logic        i_bytes_ready;
    logic        o_done;

    always #5 clk = ~clk;

    encode #(.N_COEFFS(256)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_start        (i_start),
        .i_l            (i_l),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_bytes        (o_bytes),
        .o_bytes_valid  (o_bytes_valid),
        .i_bytes_ready  (i_bytes_ready),
        .o_done         (o_done)
    );

    typedef struct {
        int          l;
        int          pat;        // 0: 1,0,1,0  1: i%16  2: random  3: 0x123,0x456,random
        int          bp_word;    // word index to stall on, -1 for none
        int          bp_cycles;
        logic [63:0] w0;
        logic [63:0] w0_mask;    // zero when word 0 has no hand value
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    int          coeffs[256];
    logic [63:0] exp_w[48];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bit-serial reference: place every stream bit into its byte/bit slot.
    task automatic build_model(input int l);
        for (int w = 0; w < 48; w++) exp_w[w] = '0;
        for (int k = 0; k < 256 * l; k++) begin
            int ci;
            int j;
            int w;
            int byt;
            int bp;
            ci  = k / l;
            j   = k % l;
            w   = k / 64;
            byt = (k % 64) / 8;
            bp  = k % 8;
            if (((coeffs[ci] >> j) & 1) != 0) exp_w[w][56 - 8*byt + bp] = 1'b1;
        end
    endtask

    task automatic fill_coeffs(input int l, input int pat);
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       coeffs[i] = (i % 2 == 0) ? 1 : 0;
                1:       coeffs[i] = i % 16;
                3:       coeffs[i] = (i == 0) ? 'h123 : (i == 1) ? 'h456 : int'($urandom_range(0, 4095));
                default: coeffs[i] = int'($urandom_range(0, (1 << l) - 1));
            endcase
        end
    endtask

    // Drives one polynomial; abort_at > 0 stops driving once that many coefficients were offered.
    task automatic run_poly(input int l, input int bp_word, input int bp_cycles,
                            input int abort_at, output logic [63:0] w0);
        int          ci = 0;
        int          wi = 0;
        int          held = 0;
        int          dones = 0;
        int          cyc = 0;
        logic [11:0] mask;
        logic [63:0] held_word;
        held_word = '0;
        w0   = '0;
        mask = 12'((1 << l) - 1);
        build_model(l);
        @(negedge clk);
        i_start = 1'b1;
        i_l     = 4'(l);
        @(negedge clk);
        i_start = 1'b0;
        while (cyc < 4000) begin
            i_coeffs_valid = (ci < 256);
            i_coeffs       = (12'($urandom) & ~mask) | 12'(coeffs[ci % 256]);
            // Restart attempts and width changes mid-polynomial must be ignored.
            i_start        = (cyc % 7 == 3);
            i_l            = (l == 4) ? 4'd12 : 4'd4;
            if (o_bytes_valid && wi == bp_word && held < bp_cycles) begin
                i_bytes_ready = 1'b0;
                if (held > 0) begin
                    check($sformatf("l%0d_stall_bytes", l), o_bytes, held_word);
                    check($sformatf("l%0d_stall_ready", l), 64'(o_coeffs_ready), 64'd0);
                end
                held_word = o_bytes;
                held++;
            end else begin
                i_bytes_ready = 1'b1;
            end
            #1;
            if (o_done) dones++;
            if (o_coeffs_ready && i_coeffs_valid) ci++;
            if (o_bytes_valid && i_bytes_ready) begin
                if (wi < 48) check($sformatf("l%0d_w%0d", l, wi), o_bytes, exp_w[wi]);
                if (wi == 0) w0 = o_bytes;
                wi++;
            end
            if (abort_at > 0 && ci >= abort_at) break;
            if (o_done) break;
            @(negedge clk);
            cyc++;
        end
        i_start        = 1'b0;
        i_coeffs_valid = 1'b0;
        i_bytes_ready  = 1'b0;
        if (abort_at > 0) return;
        check($sformatf("l%0d_timeout", l), 64'(cyc < 4000), 64'd1);
        check($sformatf("l%0d_words", l), 64'(wi), 64'(4 * l));
        check($sformatf("l%0d_done_pulses", l), 64'(dones), 64'd1);
        @(negedge clk);
        check($sformatf("l%0d_done_low", l), 64'(o_done), 64'd0);
        check($sformatf("l%0d_idle_ready", l), 64'(o_coeffs_ready), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bytes"}, o_bytes, 64'd0);
        check({tag, "_bvalid"}, 64'(o_bytes_valid), 64'd0);
        check({tag, "_cready"}, 64'(o_coeffs_ready), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [63:0] w0;

        // c0 | c1<<12 = 0x456123 gives stream bytes 23 61 45.
        vecs[0] = '{l: 1,  pat: 0, bp_word: -1, bp_cycles: 0, w0: 64'h5555_5555_5555_5555, w0_mask: '1};
        vecs[1] = '{l: 12, pat: 3, bp_word: -1, bp_cycles: 0, w0: 64'h2361_4500_0000_0000, w0_mask: 64'hFFFF_FF00_0000_0000};
        vecs[2] = '{l: 4,  pat: 1, bp_word: -1, bp_cycles: 0, w0: 64'h1032_5476_98BA_DCFE, w0_mask: '1};
        vecs[3] = '{l: 11, pat: 2, bp_word: 3,  bp_cycles: 5, w0: 64'd0, w0_mask: 64'd0};
        vecs[4] = '{l: 5,  pat: 2, bp_word: -1, bp_cycles: 0, w0: 64'd0, w0_mask: 64'd0};
        vecs[5] = '{l: 10, pat: 2, bp_word: 7,  bp_cycles: 3, w0: 64'd0, w0_mask: 64'd0};
        vecs[6] = '{l: 12, pat: 2, bp_word: 47, bp_cycles: 4, w0: 64'd0, w0_mask: 64'd0};
        vecs[7] = '{l: 1,  pat: 2, bp_word: 0,  bp_cycles: 2, w0: 64'd0, w0_mask: 64'd0};

        rstn           = 1'b0;
        i_start        = 1'b0;
        i_l            = 4'd0;
        i_coeffs       = '0;
        i_coeffs_valid = 1'b0;
        i_bytes_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        for (int v = 0; v < 8; v++) begin
            fill_coeffs(vecs[v].l, vecs[v].pat);
            run_poly(vecs[v].l, vecs[v].bp_word, vecs[v].bp_cycles, 0, w0);
            if (vecs[v].w0_mask != 64'd0)
                check($sformatf("vec%0d_word0", v), w0 & vecs[v].w0_mask, vecs[v].w0 & vecs[v].w0_mask);
        end

        // Illegal width: start must be ignored.
        @(negedge clk);
        i_l     = 4'd7;
        i_start = 1'b1;
        i_coeffs_valid = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("illegal_l_ready", 64'(o_coeffs_ready), 64'd0);
            check("illegal_l_bvalid", 64'(o_bytes_valid), 64'd0);
            @(negedge clk);
        end
        i_coeffs_valid = 1'b0;
        fill_coeffs(5, 2);
        run_poly(5, -1, 0, 0, w0);

        // Reset mid-polynomial, then a clean rerun with the same coefficients.
        fill_coeffs(10, 2);
        run_poly(10, -1, 0, 100, w0);
        rstn = 1'b0;
        #2;
        check_all_zero("midrst");
        @(negedge clk);
        rstn = 1'b1;
        run_poly(10, 2, 2, 0, w0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
